// File: rtl/pcm_pkg.sv
// Shared types and constants for the PCM frame feeder path.
package pcm_pkg;

    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned FRAME_BITS  = 32;
    localparam int unsigned FRAME_CNT_W = $clog2(FRAME_BITS);

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_sample_t;

    // True on the last bit of a frame, where the serializer loads its shift register.
    function automatic logic is_load_cycle(input logic [FRAME_CNT_W-1:0] cnt);
        return cnt == FRAME_CNT_W'(FRAME_BITS - 1);
    endfunction

endpackage

// File: rtl/pcm_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter; head is read combinationally.
module pcm_sync_fifo
    import pcm_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter type         data_t = stereo_sample_t
) (
    input  logic                    bit_clock_in,
    input  logic                    rst_active_high,
    input  logic                    push,
    input  data_t                   push_data,
    input  logic                    pop,
    output data_t                   head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    data_t             mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign level   = level_q;

    // Pointers wrap naturally; level tracks occupancy so full and empty stay unambiguous.
    always_ff @(posedge bit_clock_in) begin
        if (rst_active_high) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge bit_clock_in) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pcm_frame_feeder.sv
// Stereo sample FIFO plus frame pacer feeding the PCM serializer, one sample per 32-bit frame.
// Build option PCM_FEEDER_HOLD_LAST_EN: repeat the last sample on underflow instead of sending silence.
module pcm_frame_feeder
    import pcm_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    bit_clock_in,
    input  logic                    rst_active_high,
    input  logic [15:0]             in_left,
    input  logic [15:0]             in_right,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [15:0]             pcm_data_left,
    output logic [15:0]             pcm_data_right,
    output logic                    pcm_data_valid,
    output logic                    frame_strobe,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [CNT_W-1:0]        underflow_count
);

    logic [FRAME_CNT_W-1:0] frame_cnt;
    stereo_sample_t         in_sample;
    stereo_sample_t         fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   load;
    logic                   underflow;
    logic [SAMPLE_W-1:0]    left_d;
    logic [SAMPLE_W-1:0]    right_d;
    logic                   valid_d;
    logic [CNT_W-1:0]       underflow_d;

    assign in_sample.left  = in_left;
    assign in_sample.right = in_right;

    // Frame counter free-runs from reset so it stays aligned with the serializer's bit counter.
    always_ff @(posedge bit_clock_in) begin
        if (rst_active_high) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

    assign frame_strobe = is_load_cycle(frame_cnt);
    assign load         = frame_strobe;
    assign in_ready     = ~fifo_full;
    assign fifo_push    = in_valid & in_ready;
    assign fifo_pop     = load & ~fifo_empty;
    assign underflow    = load & fifo_empty;

    pcm_sync_fifo #(
        .DEPTH  (DEPTH),
        .data_t (stereo_sample_t)
    ) u_fifo (
        .bit_clock_in    (bit_clock_in),
        .rst_active_high (rst_active_high),
        .push            (fifo_push),
        .push_data       (in_sample),
        .pop             (fifo_pop),
        .head            (fifo_head),
        .full            (fifo_full),
        .empty           (fifo_empty),
        .level           (fifo_level)
    );

    // Next presented sample: only the load edge may change it.
    always_comb begin
        left_d      = pcm_data_left;
        right_d     = pcm_data_right;
        valid_d     = pcm_data_valid;
        underflow_d = underflow_count;
        if (fifo_pop) begin
            left_d  = fifo_head.left;
            right_d = fifo_head.right;
            valid_d = 1'b1;
        end else if (underflow) begin
`ifdef PCM_FEEDER_HOLD_LAST_EN
            left_d  = pcm_data_left;
            right_d = pcm_data_right;
            valid_d = pcm_data_valid;
`else
            left_d  = '0;
            right_d = '0;
            valid_d = 1'b0;
`endif
            if (underflow_count != '1) begin
                underflow_d = underflow_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge bit_clock_in) begin
        if (rst_active_high) begin
            pcm_data_left   <= '0;
            pcm_data_right  <= '0;
            pcm_data_valid  <= 1'b0;
            underflow_count <= '0;
        end else begin
            pcm_data_left   <= left_d;
            pcm_data_right  <= right_d;
            pcm_data_valid  <= valid_d;
            underflow_count <= underflow_d;
        end
    end

endmodule
